led_pwm_fader: RTL

LED_PWM_FADER -- requirements
Module: led_pwm_fader

---
 rtl/led_pkg.sv | 14 +
 rtl/led_pwm_channel.sv | 55 +++++
 rtl/led_pwm_fader.sv | 103 ++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the RGB LED PWM fader: FSM states and channel indices.
package led_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  localparam int unsigned CH_RED   = 0;
  localparam int unsigned CH_BLUE  = 1;
  localparam int unsigned CH_GREEN = 2;
  localparam int unsigned CH_NUM   = 3;

endpackage

// File: rtl/led_pwm_channel.sv
// One colour channel: brightness level that steps toward its on/off target, duty mapping
// (quadratic when LED_GAMMA_EN is defined, linear otherwise) and registered PWM compare.
module led_pwm_channel #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step,
  input  logic                target_on,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                at_target_next_c,
  output logic                led
);

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] level_next;
  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] duty;

  assign target = {PWM_BITS{target_on}};

  // Move one count toward the target per step; target is always 0 or full scale, so no wrap.
  always_comb begin
    level_next = level;
    if (step) begin
      if (level < target) begin
        level_next = level + PWM_BITS'(1);
      end else if (level > target) begin
        level_next = level - PWM_BITS'(1);
      end
    end
  end

  assign at_target_next_c = (level_next == target);

`ifdef LED_GAMMA_EN
  logic [2*PWM_BITS-1:0] square;

  assign square = (2*PWM_BITS)'(level) * (2*PWM_BITS)'(level);
  assign duty   = PWM_BITS'(square >> PWM_BITS);
`else
  assign duty = level;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      led   <= 1'b0;
    end else begin
      level <= level_next;
      led   <= (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/led_pwm_fader.sv
// RGB LED fader: accepts an on/off colour, ramps each channel one level per STEP_DIV cycles.
// Optional quadratic brightness curve via macro LED_GAMMA_EN.
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP_DIV = 250000
) (
  input  logic       SYSCLK,
  input  logic       SYSRST_N,
  input  logic [2:0] COLOR_IN,
  input  logic       COLOR_VALID,
  output logic       COLOR_READY,
  output logic       BUSY,
  output logic       LED_RED,
  output logic       LED_BLUE,
  output logic       LED_GREEN
);

  localparam int unsigned STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

  state_t              state;
  state_t              state_next;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic [CH_NUM-1:0]   target;
  logic [CH_NUM-1:0]   done_c;
  logic                accept_c;
  logic                step_tick_c;

  assign accept_c    = (state == IDLE) && COLOR_VALID && COLOR_READY;
  assign step_tick_c = (state == FADE) && (step_cnt == STEP_LAST);

  always_ff @(posedge SYSCLK or negedge SYSRST_N) begin
    if (!SYSRST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Leave FADE once every channel is (or is about to be) at its target.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_c) state_next = FADE;
      FADE:    if (&done_c) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge SYSRST_N) begin
    if (!SYSRST_N) begin
      COLOR_READY <= 1'b0;
      BUSY        <= 1'b0;
      pwm_cnt     <= '0;
      step_cnt    <= '0;
      target      <= '0;
    end else begin
      COLOR_READY <= (state_next == IDLE);
      BUSY        <= (state_next == FADE);
      pwm_cnt     <= pwm_cnt + PWM_BITS'(1);
      if (accept_c) begin
        target   <= COLOR_IN;
        step_cnt <= '0;
      end else if (state == FADE) begin
        step_cnt <= step_tick_c ? '0 : step_cnt + STEP_W'(1);
      end
    end
  end

  led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_red (
    .clk              (SYSCLK),
    .rst_n            (SYSRST_N),
    .step             (step_tick_c),
    .target_on        (target[CH_RED]),
    .pwm_cnt          (pwm_cnt),
    .at_target_next_c (done_c[CH_RED]),
    .led              (LED_RED)
  );

  led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_blue (
    .clk              (SYSCLK),
    .rst_n            (SYSRST_N),
    .step             (step_tick_c),
    .target_on        (target[CH_BLUE]),
    .pwm_cnt          (pwm_cnt),
    .at_target_next_c (done_c[CH_BLUE]),
    .led              (LED_BLUE)
  );

  led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_green (
    .clk              (SYSCLK),
    .rst_n            (SYSRST_N),
    .step             (step_tick_c),
    .target_on        (target[CH_GREEN]),
    .pwm_cnt          (pwm_cnt),
    .at_target_next_c (done_c[CH_GREEN]),
    .led              (LED_GREEN)
  );

endmodule
